// File: rtl/gnrl_dconv_decim_pkg.sv
// Shared types and constants for the fs/4 downconverter/decimator slice.
// Holds the control state encoding, the mixer phase codes and the AC-sample width helper.
package gnrl_dconv_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dconv_state_e;

  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;

  // Unsigned sample minus signed DC term needs two extra bits to stay exact.
  function automatic int ac_width(input int adc_width);
    return adc_width + 2;
  endfunction

endpackage

// File: rtl/gnrl_dconv_decim_if.sv
// Output handshake bundle of the downconverter: I/Q result with valid/ready.
// The design side drives the result; the consumer side drives ready.
interface gnrl_dconv_decim_if #(
  parameter int ACC_WIDTH = 24
);
  logic signed [ACC_WIDTH-1:0] out_i;
  logic signed [ACC_WIDTH-1:0] out_q;
  logic                        out_valid;
  logic                        out_ready;

  modport master (output out_i, output out_q, output out_valid, input out_ready);
  modport slave  (input out_i, input out_q, input out_valid, output out_ready);
endinterface

// File: rtl/gnrl_fs4_mixer.sv
// Combinational DC removal and fs/4 mixing with the 0/1/0/-1 sequence.
// Output width is exact: no saturation or wrap for any input combination.
module gnrl_fs4_mixer
  import gnrl_dconv_pkg::*;
#(
  parameter int ADC_WIDTH = 14
) (
  input  logic [ADC_WIDTH-1:0]                     adc_data_in,
  input  logic signed [ADC_WIDTH:0]                adc_dcval_subtractor,
  input  logic [1:0]                               phase,
  output logic signed [ac_width(ADC_WIDTH)-1:0]    mix_i,
  output logic signed [ac_width(ADC_WIDTH)-1:0]    mix_q
);
  localparam int AW = ac_width(ADC_WIDTH);

  logic signed [AW-1:0] ac_s;
  logic signed [AW-1:0] neg_s;

  assign ac_s  = $signed({2'b00, adc_data_in}) -
                 $signed({adc_dcval_subtractor[ADC_WIDTH], adc_dcval_subtractor});
  assign neg_s = -ac_s;

  // Route +/-ac to I or Q according to the current phase.
  always_comb begin
    mix_i = {AW{1'b0}};
    mix_q = {AW{1'b0}};
    case (phase)
      PH_0:    mix_q = ac_s;
      PH_1:    mix_i = ac_s;
      PH_2:    mix_q = neg_s;
      PH_3:    mix_i = neg_s;
      default: begin
        mix_i = {AW{1'b0}};
        mix_q = {AW{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/gnrl_dconv_decim.sv
// fs/4 quadrature downconverter with accumulate-and-dump decimation by a runtime factor N.
// A single holding register feeds the valid/ready output; dumps that find it full set overrun.
module gnrl_dconv_decim
  import gnrl_dconv_pkg::*;
#(
  parameter int ADC_WIDTH = 14,
  parameter int DECIM_W   = 8,
  parameter int ACC_WIDTH = ADC_WIDTH + 2 + DECIM_W
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [ADC_WIDTH-1:0]     adc_data_in,
  input  logic signed [ADC_WIDTH:0] adc_dcval_subtractor,
  input  logic                     conv_en,
  input  logic [1:0]               phase_init,
  input  logic [DECIM_W-1:0]       decim_factor,
  gnrl_dconv_decim_if.master       out_if,
  output logic                     overrun,
  input  logic                     overrun_clr
);
  localparam int AW = ac_width(ADC_WIDTH);

  if (ACC_WIDTH < ADC_WIDTH + 2 + DECIM_W) begin : g_acc_width_check
    $error("gnrl_dconv_decim: ACC_WIDTH too small for ADC_WIDTH+2+DECIM_W");
  end

  dconv_state_e                state_r;
  logic [1:0]                  phase_r;
  logic [DECIM_W-1:0]          n_r;
  logic [DECIM_W-1:0]          count_r;
  logic signed [ACC_WIDTH-1:0] acc_i_r;
  logic signed [ACC_WIDTH-1:0] acc_q_r;
  logic signed [ACC_WIDTH-1:0] out_i_r;
  logic signed [ACC_WIDTH-1:0] out_q_r;
  logic                        out_valid_r;
  logic                        overrun_r;

  logic signed [AW-1:0]        mix_i_s;
  logic signed [AW-1:0]        mix_q_s;
  logic signed [ACC_WIDTH-1:0] sum_i_s;
  logic signed [ACC_WIDTH-1:0] sum_q_s;
  logic                        dump_s;
  logic                        load_s;
  logic                        drop_s;

  gnrl_fs4_mixer #(.ADC_WIDTH(ADC_WIDTH)) u_mixer (
    .adc_data_in          (adc_data_in),
    .adc_dcval_subtractor (adc_dcval_subtractor),
    .phase                (phase_r),
    .mix_i                (mix_i_s),
    .mix_q                (mix_q_s)
  );

  // Running sums including the current sample, plus dump/load/drop decisions.
  always_comb begin
    sum_i_s = acc_i_r + {{(ACC_WIDTH-AW){mix_i_s[AW-1]}}, mix_i_s};
    sum_q_s = acc_q_r + {{(ACC_WIDTH-AW){mix_q_s[AW-1]}}, mix_q_s};
    dump_s  = (state_r == RUN) && conv_en && (count_r == (n_r - {{(DECIM_W-1){1'b0}}, 1'b1}));
    load_s  = dump_s && (!out_valid_r || out_if.out_ready);
    drop_s  = dump_s && out_valid_r && !out_if.out_ready;
  end

  // Control FSM, accumulators, holding register and sticky overrun.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r     <= IDLE;
      phase_r     <= PH_0;
      n_r         <= {DECIM_W{1'b0}};
      count_r     <= {DECIM_W{1'b0}};
      acc_i_r     <= {ACC_WIDTH{1'b0}};
      acc_q_r     <= {ACC_WIDTH{1'b0}};
      out_i_r     <= {ACC_WIDTH{1'b0}};
      out_q_r     <= {ACC_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (conv_en) begin
            state_r <= RUN;
            phase_r <= phase_init;
            n_r     <= (decim_factor == {DECIM_W{1'b0}}) ? {{(DECIM_W-1){1'b0}}, 1'b1} : decim_factor;
            count_r <= {DECIM_W{1'b0}};
            acc_i_r <= {ACC_WIDTH{1'b0}};
            acc_q_r <= {ACC_WIDTH{1'b0}};
          end
        end
        RUN: begin
          if (conv_en) begin
            phase_r <= phase_r + 2'd1;
            if (dump_s) begin
              count_r <= {DECIM_W{1'b0}};
              acc_i_r <= {ACC_WIDTH{1'b0}};
              acc_q_r <= {ACC_WIDTH{1'b0}};
            end else begin
              count_r <= count_r + {{(DECIM_W-1){1'b0}}, 1'b1};
              acc_i_r <= sum_i_s;
              acc_q_r <= sum_q_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase

      if (load_s) begin
        out_i_r     <= sum_i_s;
        out_q_r     <= sum_q_s;
        out_valid_r <= 1'b1;
      end else if (out_valid_r && out_if.out_ready) begin
        out_valid_r <= 1'b0;
      end

      // A new overrun event takes priority over a coincident clear.
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (overrun_clr) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign out_if.out_i     = out_i_r;
  assign out_if.out_q     = out_q_r;
  assign out_if.out_valid = out_valid_r;
  assign overrun          = overrun_r;

endmodule

// File: tb/tb_gnrl_dconv_decim.sv
// Directed self-checking bench for gnrl_dconv_decim with hand-computed expected values.
module tb_gnrl_dconv_decim;
  import gnrl_dconv_pkg::*;

  localparam int ADC_WIDTH = 14;
  localparam int DECIM_W   = 8;
  localparam int ACC_WIDTH = ADC_WIDTH + 2 + DECIM_W;

  logic                      CLK;
  logic                      RESET;
  logic [ADC_WIDTH-1:0]      adc_data_in;
  logic signed [ADC_WIDTH:0] adc_dcval_subtractor;
  logic                      conv_en;
  logic [1:0]                phase_init;
  logic [DECIM_W-1:0]        decim_factor;
  logic                      overrun;
  logic                      overrun_clr;

  int checks = 0;
  int errors = 0;

  gnrl_dconv_decim_if #(.ACC_WIDTH(ACC_WIDTH)) bus ();

  gnrl_dconv_decim #(
    .ADC_WIDTH (ADC_WIDTH),
    .DECIM_W   (DECIM_W),
    .ACC_WIDTH (ACC_WIDTH)
  ) dut (
    .CLK                  (CLK),
    .RESET                (RESET),
    .adc_data_in          (adc_data_in),
    .adc_dcval_subtractor (adc_dcval_subtractor),
    .conv_en              (conv_en),
    .phase_init           (phase_init),
    .decim_factor         (decim_factor),
    .out_if               (bus.master),
    .overrun              (overrun),
    .overrun_clr          (overrun_clr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    RESET = 1'b1;
    adc_data_in = '0;
    adc_dcval_subtractor = '0;
    conv_en = 1'b0;
    phase_init = 2'd0;
    decim_factor = 8'd0;
    overrun_clr = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_i", bus.out_i, 0);
    chk("rst_q", bus.out_q, 0);
    chk("rst_ovr", overrun, 0);
    RESET = 1'b0;
    step();

    // N=1 pure mixer, ac=100, phase_init 0
    adc_dcval_subtractor = 15'sd8192;
    adc_data_in = 14'd8292;
    decim_factor = 8'd1;
    phase_init = 2'd0;
    bus.out_ready = 1'b1;
    conv_en = 1'b1;
    step();
    chk("n1_pre_valid", bus.out_valid, 0);
    step(); chk("n1_v0", bus.out_valid, 1); chk("n1_i0", bus.out_i, 0);    chk("n1_q0", bus.out_q, 100);
    step(); chk("n1_i1", bus.out_i, 100);  chk("n1_q1", bus.out_q, 0);
    step(); chk("n1_i2", bus.out_i, 0);    chk("n1_q2", bus.out_q, -100);
    step(); chk("n1_i3", bus.out_i, -100); chk("n1_q3", bus.out_q, 0);
    step(); chk("n1_i4", bus.out_i, 0);    chk("n1_q4", bus.out_q, 100);
    conv_en = 1'b0;
    step();
    chk("n1_stop_valid", bus.out_valid, 0);

    // decim_factor 0 behaves as 1, phase_init 3
    decim_factor = 8'd0;
    phase_init = 2'd3;
    conv_en = 1'b1;
    step();
    step();
    chk("n0_valid", bus.out_valid, 1);
    chk("n0_i", bus.out_i, -100);
    chk("n0_q", bus.out_q, 0);
    conv_en = 1'b0;
    step();

    // N=4 quadrature cancellation, one pulse every 4 samples
    adc_dcval_subtractor = 15'sd0;
    adc_data_in = 14'd16383;
    decim_factor = 8'd4;
    phase_init = 2'd1;
    conv_en = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) begin
        step();
        chk("n4_valid", bus.out_valid, (j == 3) ? 1 : 0);
      end
      chk("n4_i", bus.out_i, 0);
      chk("n4_q", bus.out_q, 0);
    end
    conv_en = 1'b0;
    step();

    // N=255 ramp, subtractor -8192, phase_init 2
    adc_dcval_subtractor = -15'sd8192;
    decim_factor = 8'd255;
    phase_init = 2'd2;
    conv_en = 1'b1;
    step();
    for (int k = 0; k < 255; k++) begin
      adc_data_in = 14'(k);
      step();
      if (k == 253) chk("n255_early_valid", bus.out_valid, 0);
    end
    chk("n255_valid", bus.out_valid, 1);
    chk("n255_i", bus.out_i, -8319);
    chk("n255_q", bus.out_q, 128);
    conv_en = 1'b0;
    step();
    chk("n255_ack", bus.out_valid, 0);

    // Backpressure with N=2, ac=100
    adc_dcval_subtractor = 15'sd8192;
    adc_data_in = 14'd8292;
    decim_factor = 8'd2;
    phase_init = 2'd0;
    bus.out_ready = 1'b0;
    conv_en = 1'b1;
    step();
    step();
    step();
    chk("bp_valid1", bus.out_valid, 1);
    chk("bp_i1", bus.out_i, 100);
    chk("bp_q1", bus.out_q, 100);
    step();
    chk("bp_ovr_pre", overrun, 0);
    step();
    chk("bp_ovr_set", overrun, 1);
    chk("bp_i_held", bus.out_i, 100);
    chk("bp_q_held", bus.out_q, 100);
    step();
    overrun_clr = 1'b1;
    step();
    chk("bp_ovr_setwins", overrun, 1);
    conv_en = 1'b0;
    step();
    chk("bp_ovr_clr", overrun, 0);
    chk("bp_valid_kept", bus.out_valid, 1);
    chk("bp_i_kept", bus.out_i, 100);
    overrun_clr = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("bp_ack", bus.out_valid, 0);

    // Start/stop: partial sum of 3 samples discarded
    adc_data_in = 14'd9192;
    decim_factor = 8'd8;
    phase_init = 2'd1;
    conv_en = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ss_partial_valid", bus.out_valid, 0);
    end
    conv_en = 1'b0;
    step();
    chk("ss_stop_valid", bus.out_valid, 0);
    conv_en = 1'b1;
    step();
    phase_init = 2'd3;
    decim_factor = 8'd2;
    for (int k = 0; k < 8; k++) begin
      adc_data_in = 14'(8192 + 10 * (k + 1));
      step();
      chk("ss_valid", bus.out_valid, (k == 7) ? 1 : 0);
    end
    chk("ss_i", bus.out_i, -40);
    chk("ss_q", bus.out_q, 40);
    conv_en = 1'b0;
    step();

    // RESET mid-accumulation while holding a result
    adc_data_in = 14'd8292;
    decim_factor = 8'd2;
    phase_init = 2'd0;
    bus.out_ready = 1'b0;
    conv_en = 1'b1;
    step();
    step();
    step();
    chk("rr_valid_before", bus.out_valid, 1);
    step();
    #3;
    RESET = 1'b1;
    #1;
    chk("rr_valid", bus.out_valid, 0);
    chk("rr_i", bus.out_i, 0);
    chk("rr_q", bus.out_q, 0);
    chk("rr_ovr", overrun, 0);
    step();
    RESET = 1'b0;
    adc_data_in = 14'd8199;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rr_fresh_v0", bus.out_valid, 0);
    step();
    chk("rr_fresh_v1", bus.out_valid, 1);
    chk("rr_fresh_i", bus.out_i, 7);
    chk("rr_fresh_q", bus.out_q, 7);
    conv_en = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gnrl_dconv_decim.md
Name: gnrl_dconv_decim

Overview:
- Parametrised fs/4 quadrature downconverter with integrated accumulate-and-dump decimation and a valid/ready output handshake.
- Removes the DC offset from unsigned ADC samples, mixes with the 0/1/0/-1 sequence into I/Q, and sums N mixed samples per output.
- Sits between the ADC capture front-end and the NMR echo acquisition FIFO; reduces the data rate by a runtime-selectable factor.

Parameters:
- ADC_WIDTH, 14, ADC sample width (unsigned).
- DECIM_W, 8, width of decimation-factor input; max factor 2^DECIM_W-1.
- ACC_WIDTH, ADC_WIDTH+2+DECIM_W, I/Q accumulator/output width; must be >= ADC_WIDTH+2+DECIM_W (elaboration error otherwise).

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- adc_data_in  in  ADC_WIDTH  unsigned ADC sample, one per CLK while conv_en=1
- adc_dcval_subtractor  in  ADC_WIDTH+1  signed DC subtractor, sampled every cycle
- conv_en  in  1  run enable; rising level starts a run
- phase_init  in  2  mixer phase loaded at run start
- decim_factor  in  DECIM_W  samples per output; 0 treated as 1; latched at run start
- out_i  out  ACC_WIDTH  signed accumulated in-phase result
- out_q  out  ACC_WIDTH  signed accumulated quadrature result
- out_valid  out  1  output holding register full
- out_ready  in  1  consumer accepts when out_valid & out_ready
- overrun  out  1  sticky: a dump was lost because the holding register was full
- overrun_clr  in  1  synchronous clear of overrun

Behaviour:
- Reset: state=IDLE, phase=0, sample count=0, accumulators=0, out_i=out_q=0, out_valid=0, overrun=0.
- AC sample (combinational): ac = {2'b00,adc_data_in} - sign_extend(adc_dcval_subtractor), ADC_WIDTH+2 bits signed; exact, no overflow (range -(2^ADC_WIDTH-1) .. 2^(ADC_WIDTH+1)-1).
- Mixer by phase p: p=0 I=0,Q=ac; p=1 I=ac,Q=0; p=2 I=0,Q=-ac; p=3 I=-ac,Q=0. Negation two's complement, exact in ADC_WIDTH+2 bits.
- States: IDLE, RUN.
- IDLE -> RUN when conv_en=1.
  - On the transition: phase <= phase_init; N <= max(decim_factor,1); count <= 0; accumulators <= 0.
  - The first sample is taken on the first cycle in RUN.
- RUN, conv_en=1, each CLK:
  - acc += sign_extend(mixed).
  - phase <= phase+1 (mod 4 wrap).
  - count <= count+1.
- Dump when count = N-1 in a RUN cycle:
  - Final sum (acc + current mixed) goes to the holding register.
  - acc <= 0, count <= 0.
  - Phase continues without reset.
- Latency: out_valid rises on the CLK edge that consumes the N-th sample (1 cycle after that sample is presented).
- RUN -> IDLE when conv_en=0.
  - Partial accumulation is discarded.
  - Holding register and out_valid are kept until accepted.
- Holding register:
  - out_valid cleared on handshake (out_valid & out_ready).
  - Dump with out_valid=0, or with a simultaneous handshake: new data loaded, out_valid=1. No bubble, no loss.
  - Dump while out_valid=1 and out_ready=0: new data dropped, old data kept, overrun <= 1.
- overrun: cleared by overrun_clr. If overrun_clr coincides with a new overrun event, set wins.
- decim_factor and phase_init changes during RUN: ignored until the next IDLE->RUN.
- N=1: a dump every RUN cycle (pure mixer with registered output).
- RESET asserted mid-run: immediate return to reset values; a pending output is lost.

Decomposition:
- Shared package gnrl_dconv_pkg:
  - state enum (IDLE, RUN);
  - mixer phase constants (PH_0..PH_3);
  - function for the ADC_WIDTH+2 AC width.
- One natural sub-module: gnrl_fs4_mixer (combinational AC subtract + 4-phase mix, parameter ADC_WIDTH).
- Accumulator, control FSM and holding register stay in the top level.

Test Plan:
- Mixer, N=1, phase_init=0, subtractor=8192, adc=8292 constant, out_ready=1 -> successive outputs (I,Q) = (0,100),(100,0),(0,-100),(-100,0), repeating.
- N=4, phase_init=1, subtractor=0, adc=16383 constant, out_ready=1 -> every output I=0, Q=0 (quadrature cancellation); out_valid pulses once per 4 samples, first pulse 4 cycles after entering RUN.
- N=255, subtractor=-8192, adc ramp 0..254 with phase fixed by stimulus -> out_i/out_q match a bit-exact software model; no wrap in ACC_WIDTH.
- Backpressure: N=2, out_ready=0 for 6 samples -> first result held unchanged, overrun=1 after the second dump; a same-cycle overrun_clr and overrun event leaves overrun=1; overrun_clr alone -> 0.
- Start/stop: conv_en drops after 3 of N=8 samples -> no output, partial sum discarded. Re-enable -> the next output covers exactly 8 fresh samples starting at phase_init.
- RESET asserted mid-accumulation with out_valid=1 -> all outputs 0 in the same cycle; post-reset run behaves as a fresh start.
